small_async_fifo_sc: RTL and testbench



---
 rtl/small_async_fifo_sc_pkg.sv | 23 ++
 rtl/small_async_fifo_sc_mem.sv | 25 ++
 rtl/small_async_fifo_sc.sv | 83 ++++++++
 tb/tb_small_async_fifo_sc.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/small_async_fifo_sc_pkg.sv
// Shared types for the single-clock fall-through FIFO: occupancy update
// decode used by the top-level pointer/count logic.
package small_async_fifo_sc_pkg;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    // A simultaneous accepted push and pop leaves occupancy unchanged.
    function automatic cnt_op_e cnt_op(input logic wacc, input logic racc);
        cnt_op_e op;
        op = CNT_HOLD;
        if (wacc && !racc) begin
            op = CNT_INC;
        end else if (racc && !wacc) begin
            op = CNT_DEC;
        end
        return op;
    endfunction

endpackage

// File: rtl/small_async_fifo_sc_mem.sv
// DSIZE x 2^ASIZE storage with synchronous write and asynchronous read,
// so the head word falls through to the read port without a cycle of delay.
module small_fifo_mem #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    logic [DSIZE-1:0] mem_reg [2**ASIZE];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/small_async_fifo_sc.sv
// Single-clock first-word-fall-through FIFO with almost-full/almost-empty
// flags; all flags decode from the registered occupancy count.
module small_async_fifo_sc
    import small_async_fifo_sc_pkg::*;
#(
    parameter int DSIZE             = 8,
    parameter int ASIZE             = 4,
    parameter int ALMOST_FULL_SIZE  = 14,
    parameter int ALMOST_EMPTY_SIZE = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    output logic             w_almost_full,
    output logic [DSIZE-1:0] rdata,
    input  logic             rinc,
    output logic             rempty,
    output logic             r_almost_empty
);

    localparam logic [ASIZE:0] DEPTH_C = (ASIZE+1)'(2**ASIZE);
    localparam logic [ASIZE:0] AF_TH   = (ASIZE+1)'(ALMOST_FULL_SIZE);
    localparam logic [ASIZE:0] AE_TH   = (ASIZE+1)'(ALMOST_EMPTY_SIZE);

    logic [ASIZE-1:0] wptr_reg, wptr_next;
    logic [ASIZE-1:0] rptr_reg, rptr_next;
    logic [ASIZE:0]   count_reg, count_next;
    logic             wacc;
    logic             racc;

    // Full/empty are judged on the count before this edge's push/pop.
    assign wacc = winc & ~wfull;
    assign racc = rinc & ~rempty;

    always_comb begin
        wptr_next  = wptr_reg;
        rptr_next  = rptr_reg;
        count_next = count_reg;
        if (wacc) begin
            wptr_next = wptr_reg + ASIZE'(1);
        end
        if (racc) begin
            rptr_next = rptr_reg + ASIZE'(1);
        end
        case (cnt_op(wacc, racc))
            CNT_INC: count_next = count_reg + (ASIZE+1)'(1);
            CNT_DEC: count_next = count_reg - (ASIZE+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            count_reg <= count_next;
        end
    end

    assign wfull          = (count_reg == DEPTH_C);
    assign w_almost_full  = (count_reg >= AF_TH);
    assign rempty         = (count_reg == '0);
    assign r_almost_empty = (count_reg <= AE_TH);

    small_fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk   (clk),
        .we    (wacc & resetn),
        .waddr (wptr_reg),
        .wdata (wdata),
        .raddr (rptr_reg),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_small_async_fifo_sc.sv
// Directed bench for the single-clock fall-through FIFO: reset, fill, drain,
// fall-through, simultaneous access across wrap, full push+pop, mid-run reset.
module tb_small_async_fifo_sc;

    logic       clk;
    logic       resetn;
    logic [7:0] wdata;
    logic       winc;
    logic       wfull;
    logic       w_almost_full;
    logic [7:0] rdata;
    logic       rinc;
    logic       rempty;
    logic       r_almost_empty;

    int assert_cnt;
    int fail_cnt;

    small_async_fifo_sc dut (
        .clk            (clk),
        .resetn         (resetn),
        .wdata          (wdata),
        .winc           (winc),
        .wfull          (wfull),
        .w_almost_full  (w_almost_full),
        .rdata          (rdata),
        .rinc           (rinc),
        .rempty         (rempty),
        .r_almost_empty (r_almost_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {wfull, w_almost_full, rempty, r_almost_empty}
    function automatic logic [3:0] flags();
        return {wfull, w_almost_full, rempty, r_almost_empty};
    endfunction

    task automatic push(input logic [7:0] d);
        wdata = d;
        winc  = 1'b1;
        tick();
        winc  = 1'b0;
    endtask

    initial begin
        assert_cnt = 0;
        fail_cnt   = 0;
        resetn = 1'b0;
        winc   = 1'b1;
        rinc   = 1'b1;
        wdata  = 8'h77;
        #2;

        // Reset held for two edges with both requests asserted
        tick();
        tick();
        resetn = 1'b1;
        winc   = 1'b0;
        rinc   = 1'b0;
        check("reset_flags", 32'(flags()), 32'b0011);
        tick();
        check("reset_no_write", 32'(flags()), 32'b0011);

        // Fill 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            push(8'(i));
            check($sformatf("fill%0d_flags", i), 32'(flags()),
                  32'({i == 16, i >= 14, 1'b0, i <= 2}));
            if (i == 1) check("fill_head", 32'(rdata), 32'h01);
        end
        push(8'hFF);
        check("overflow_flags", 32'(flags()), 32'b1100);

        // Drain every cycle from full
        rinc = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("drain%0d_data", i), 32'(rdata), 32'(i));
            tick();
            check($sformatf("drain%0d_flags", i), 32'(flags()),
                  32'({1'b0, i <= 2, i == 16, i >= 14}));
        end
        rinc = 1'b0;

        // Fall-through of a single word
        push(8'hA5);
        check("ft_data", 32'(rdata), 32'hA5);
        check("ft_rempty", 32'(rempty), 32'd0);
        rinc = ~rempty;
        tick();
        rinc = 1'b0;
        check("ft_consumed", 32'(rempty), 32'd1);

        // Five queued, then 40 cycles of simultaneous push/pop across wrap
        for (int i = 0; i < 5; i++) push(8'(8'h20 + i));
        check("sim_pre_flags", 32'(flags()), 32'b0000);
        for (int k = 0; k < 40; k++) begin
            wdata = 8'(8'h25 + k);
            winc  = 1'b1;
            rinc  = 1'b1;
            check($sformatf("sim%0d_data", k), 32'(rdata), 32'(8'h20 + k));
            tick();
            check($sformatf("sim%0d_flags", k), 32'(flags()), 32'b0000);
        end
        winc = 1'b0;
        rinc = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("sim_tail%0d_data", k), 32'(rdata), 32'(8'h48 + k));
            check($sformatf("sim_tail%0d_rempty", k), 32'(rempty), 32'd0);
            tick();
        end
        rinc = 1'b0;
        check("sim_tail_empty", 32'(rempty), 32'd1);

        // Full with simultaneous push and pop: only the pop is taken
        for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
        check("full2_flags", 32'(flags()), 32'b1100);
        wdata = 8'hEE;
        winc  = 1'b1;
        rinc  = 1'b1;
        tick();
        winc  = 1'b0;
        check("full_rw_flags", 32'(flags()), 32'b0100);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("full_rw_drain%0d", i), 32'(rdata), 32'(8'h80 + i));
            tick();
        end
        rinc = 1'b0;
        check("full_rw_empty", 32'(rempty), 32'd1);

        // Reset mid-operation with nine words queued
        for (int i = 0; i < 9; i++) push(8'(8'h50 + i));
        check("mid_pre_flags", 32'(flags()), 32'b0000);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("mid_reset_flags", 32'(flags()), 32'b0011);
        push(8'h3C);
        check("mid_write_data", 32'(rdata), 32'h3C);
        check("mid_write_rempty", 32'(rempty), 32'd0);
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        check("mid_final_empty", 32'(rempty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
